// File: rtl/hazard_flush_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the hazard/flush controller
package hazard_pkg;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         REM_W    = 4;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// hazard_flush_ctrl_if: hazard inputs and stall/flush control lines for the pipeline registers
interface hazard_flush_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             IFID_UsesRt;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_Rt;
    logic             BranchTaken;
    logic             JumpID;
    logic             CountClear;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
        input  BranchTaken, JumpID, CountClear,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StallCount, FlushCount
    );

    modport slave (
        output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
        output BranchTaken, JumpID, CountClear,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// sat_counter: event counter that holds at all-ones, with clear taking priority over increment
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    logic [CNT_W-1:0] q_q;

    // count qualifying cycles, stop at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n)
            q_q <= '0;
        else if (clr)
            q_q <= '0;
        else if (inc && !(&q_q))
            q_q <= q_q + 1'b1;
    end

    assign q = q_q;
endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use stall and branch/jump flush control with perf counters
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL     = 1,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_flush_ctrl_if.master hz
);
    localparam logic [REM_W-1:0] STALL_REM = REM_W'(LOAD_STALL - 1);
    localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(BRANCH_PENALTY - 1);

    // control vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_FLUSH = 4'b1111;
    localparam logic [3:0] C_JUMP  = 4'b1110;
    localparam logic [3:0] C_RESET = 4'b0011;

    state_t           state_q, state_d;
    logic [REM_W-1:0] remain_q, remain_d;
    logic             lu;
    logic [3:0]       ctrl;

    // an in-flight load whose destination feeds the ID instruction; r0 never hazards
    assign lu = hz.IDEX_MemRead && (hz.IDEX_Rt != REG_ZERO) &&
                ((hz.IDEX_Rt == hz.IFID_Rs) || (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

    // state and remaining-cycle register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // next state: a taken branch overrides everything, including an active stall
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (hz.BranchTaken) begin
            state_d  = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
            remain_d = (BRANCH_PENALTY > 1) ? FLUSH_REM : '0;
        end else begin
            case (state_q)
                STALL, FLUSH: begin
                    remain_d = remain_q - 1'b1;
                    state_d  = (remain_q == 1) ? RUN : state_q;
                end
                default: begin
                    state_d  = (lu && LOAD_STALL > 1) ? STALL : RUN;
                    remain_d = (lu && LOAD_STALL > 1) ? STALL_REM : '0;
                end
            endcase
        end
    end

    // outputs: same-cycle response from state and hazard inputs
    always_comb begin
        ctrl = C_RUN;
        if (!rst_n)
            ctrl = C_RESET;
        else if (hz.BranchTaken)
            ctrl = C_FLUSH;
        else if (state_q == STALL)
            ctrl = C_STALL;
        else if (state_q == FLUSH)
            ctrl = C_FLUSH;
        else if (lu)
            ctrl = C_STALL;
        else if (hz.JumpID)
            ctrl = C_JUMP;
    end

    assign {hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXFlush} = ctrl;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.CountClear),
        .inc   (!ctrl[3]),
        .q     (hz.StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.CountClear),
        .inc   (ctrl[1]),
        .q     (hz.FlushCount)
    );
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: directed checks of stall/flush sequencing and counters on two configurations
module tb_hazard_flush_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    // instance a: LOAD_STALL=1, BRANCH_PENALTY=2, 4-bit counters (for saturation)
    hazard_flush_ctrl_if #(.CNT_W(4))  ia ();
    // instance b: LOAD_STALL=3, BRANCH_PENALTY=1, 16-bit counters
    hazard_flush_ctrl_if #(.CNT_W(16)) ib ();

    hazard_flush_ctrl #(.LOAD_STALL(1), .BRANCH_PENALTY(2), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ia.master)
    );

    hazard_flush_ctrl #(.LOAD_STALL(3), .BRANCH_PENALTY(1), .CNT_W(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ib.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected control patterns {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    localparam logic [31:0] RUN_P   = 32'hC;
    localparam logic [31:0] STALL_P = 32'h1;
    localparam logic [31:0] FLUSH_P = 32'hF;
    localparam logic [31:0] JUMP_P  = 32'hE;
    localparam logic [31:0] RESET_P = 32'h3;

    function automatic logic [31:0] outs_a();
        return 32'({ia.PCWrite, ia.IFIDWrite, ia.IFIDFlush, ia.IDEXFlush});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({ib.PCWrite, ib.IFIDWrite, ib.IFIDFlush, ib.IDEXFlush});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_a();
        ia.IFID_Rs = 5'd0; ia.IFID_Rt = 5'd0; ia.IFID_UsesRt = 1'b0;
        ia.IDEX_MemRead = 1'b0; ia.IDEX_Rt = 5'd0;
        ia.BranchTaken = 1'b0; ia.JumpID = 1'b0; ia.CountClear = 1'b0;
    endtask

    task automatic idle_b();
        ib.IFID_Rs = 5'd0; ib.IFID_Rt = 5'd0; ib.IFID_UsesRt = 1'b0;
        ib.IDEX_MemRead = 1'b0; ib.IDEX_Rt = 5'd0;
        ib.BranchTaken = 1'b0; ib.JumpID = 1'b0; ib.CountClear = 1'b0;
    endtask

    task automatic lu_a(input logic [4:0] rs);
        ia.IDEX_MemRead = 1'b1; ia.IDEX_Rt = 5'd5; ia.IFID_Rs = rs;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_a();
        idle_b();
        #1 chk("reset_outs_a", outs_a(), RESET_P);
        chk("reset_outs_b", outs_b(), RESET_P);
        cyc(); cyc();
        chk("reset_stallcnt", 32'(ia.StallCount), 32'd0);
        chk("reset_flushcnt", 32'(ia.FlushCount), 32'd0);
        rst_n = 1'b1;

        // lw $5 in EX, rs=5: one stall cycle
        lu_a(5'd5);
        #1 chk("lu_rs_stall", outs_a(), STALL_P);
        cyc();
        idle_a();
        #1 chk("lu_rs_release", outs_a(), RUN_P);
        chk("lu_rs_stallcnt", 32'(ia.StallCount), 32'd1);

        // rs and rt both match: one hazard, one count
        lu_a(5'd5); ia.IFID_Rt = 5'd5; ia.IFID_UsesRt = 1'b1;
        #1 chk("lu_both_stall", outs_a(), STALL_P);
        cyc();
        idle_a();
        #1 chk("lu_both_stallcnt", 32'(ia.StallCount), 32'd2);

        // rt match ignored when the ID instruction does not read rt
        lu_a(5'd7); ia.IFID_Rt = 5'd5; ia.IFID_UsesRt = 1'b0;
        #1 chk("rt_unused_nostall", outs_a(), RUN_P);
        ia.IFID_UsesRt = 1'b1;
        #1 chk("rt_used_stall", outs_a(), STALL_P);
        ia.IFID_UsesRt = 1'b0;

        // load to r0 with rs=r0: never a hazard
        ia.IDEX_Rt = 5'd0; ia.IFID_Rs = 5'd0;
        #1 chk("r0_nostall", outs_a(), RUN_P);
        cyc();
        idle_a();
        #1 chk("r0_stallcnt", 32'(ia.StallCount), 32'd2);

        // BRANCH_PENALTY=2: two flush cycles, load-use ignored in FLUSH
        ia.BranchTaken = 1'b1;
        #1 chk("br_cycle1", outs_a(), FLUSH_P);
        cyc();
        ia.BranchTaken = 1'b0;
        lu_a(5'd5);
        #1 chk("br_cycle2_lu_ignored", outs_a(), FLUSH_P);
        cyc();
        idle_a();
        #1 chk("br_done", outs_a(), RUN_P);
        chk("br_flushcnt", 32'(ia.FlushCount), 32'd2);
        chk("br_stallcnt", 32'(ia.StallCount), 32'd2);

        // lu with JumpID: stall wins, jump flushes once afterwards
        lu_a(5'd5); ia.JumpID = 1'b1;
        #1 chk("lu_jump_stall", outs_a(), STALL_P);
        cyc();
        ia.IDEX_MemRead = 1'b0;
        #1 chk("jump_after_stall", outs_a(), JUMP_P);
        cyc();
        idle_a();
        #1 chk("jump_done", outs_a(), RUN_P);

        // second BranchTaken inside FLUSH reloads the penalty
        ia.BranchTaken = 1'b1;
        #1 chk("reload_c1", outs_a(), FLUSH_P);
        cyc();
        #1 chk("reload_c2", outs_a(), FLUSH_P);
        cyc();
        ia.BranchTaken = 1'b0;
        #1 chk("reload_c3", outs_a(), FLUSH_P);
        cyc();
        #1 chk("reload_done", outs_a(), RUN_P);
        chk("a_flushcnt", 32'(ia.FlushCount), 32'd6);
        chk("a_stallcnt", 32'(ia.StallCount), 32'd3);

        // LOAD_STALL=3: branch in the 2nd stall cycle aborts the stall
        ib.IDEX_MemRead = 1'b1; ib.IDEX_Rt = 5'd9; ib.IFID_Rs = 5'd9;
        #1 chk("b_stall1", outs_b(), STALL_P);
        cyc();
        idle_b();
        ib.BranchTaken = 1'b1;
        #1 chk("b_stall2_branch", outs_b(), FLUSH_P);
        cyc();
        ib.BranchTaken = 1'b0;
        #1 chk("b_after_branch", outs_b(), RUN_P);
        chk("b_stallcnt1", 32'(ib.StallCount), 32'd1);
        chk("b_flushcnt1", 32'(ib.FlushCount), 32'd1);

        // LOAD_STALL=3 full sequence from a one-cycle lu pulse
        ib.IDEX_MemRead = 1'b1; ib.IDEX_Rt = 5'd9; ib.IFID_Rs = 5'd9;
        #1 chk("b_full1", outs_b(), STALL_P);
        cyc();
        idle_b();
        #1 chk("b_full2", outs_b(), STALL_P);
        cyc();
        #1 chk("b_full3", outs_b(), STALL_P);
        cyc();
        #1 chk("b_full_done", outs_b(), RUN_P);
        chk("b_stallcnt4", 32'(ib.StallCount), 32'd4);

        // reset in the middle of a FLUSH
        ia.BranchTaken = 1'b1;
        cyc();
        ia.BranchTaken = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_forced", outs_a(), RESET_P);
        cyc();
        rst_n = 1'b1;
        #1 chk("rst_state_run", outs_a(), RUN_P);
        chk("rst_stallcnt", 32'(ia.StallCount), 32'd0);
        chk("rst_flushcnt", 32'(ia.FlushCount), 32'd0);

        // 2^4+3 stall cycles saturate the 4-bit counter; clear wins over increment
        lu_a(5'd5);
        for (int i = 0; i < 19; i++) cyc();
        #1 chk("sat_stallcnt", 32'(ia.StallCount), 32'd15);
        ia.CountClear = 1'b1;
        cyc();
        idle_a();
        #1 chk("clr_stallcnt", 32'(ia.StallCount), 32'd0);
        cyc();
        #1 chk("clr_hold", 32'(ia.StallCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
